// File: rtl/dp_pipe_sched_pkg.sv
// Shared encodings for the dp tile-pipeline scheduler: job modes, FSM states
// and the rotating buffer-pointer step.
package dp_pipe_sched_pkg;

    localparam logic [1:0] M_CTXT = 2'b01;
    localparam logic [1:0] M_PTXT = 2'b10;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    function automatic logic mode_legal(input logic [1:0] m);
        return (m == M_CTXT) || (m == M_PTXT);
    endfunction

    // Buffer pointers step by one and wrap at the last buffer.
    function automatic logic [1:0] ptr_next(input logic [1:0] p, input int unsigned nb);
        return ({30'b0, p} == (nb - 1)) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/dp_pipe_sched_if.sv
// Job control, stage start/done pulses and buffer-role pointers of the
// dp tile-pipeline scheduler, bundled for the scheduler port.
interface dp_pipe_sched_if #(
    parameter int NUM_CORE      = 2,
    parameter int TILE_W        = 16,
    parameter int LOG_NUM_SPLIT = 2
);
    // Handshake: every *_start and *_done is a single-cycle pulse with no
    // back-pressure; a stage is started by its start pulse and reports back
    // with exactly one done pulse per core per tile.
    logic                     i_run;
    logic [TILE_W-1:0]        i_num_tiles;
    logic [1:0]               i_mode;
    logic                     i_axi_done;
    logic [NUM_CORE-1:0]      i_ntt_done;
    logic [NUM_CORE-1:0]      i_madd_done;
    logic                     i_wruram_done;
    logic                     o_ntt_start;
    logic                     o_madd_start;
    logic                     o_wruram_start;
    logic [1:0]               o_sel_axi;
    logic [1:0]               o_sel_ntt;
    logic [1:0]               o_sel_out;
    logic [LOG_NUM_SPLIT-1:0] o_idx_split;
    logic                     o_busy;
    logic                     o_job_done;
    logic                     o_err;
    logic [1:0]               o_dbg_state;

    modport slave (
        input  i_run, i_num_tiles, i_mode, i_axi_done, i_ntt_done, i_madd_done, i_wruram_done,
        output o_ntt_start, o_madd_start, o_wruram_start, o_sel_axi, o_sel_ntt, o_sel_out,
               o_idx_split, o_busy, o_job_done, o_err, o_dbg_state
    );

    modport master (
        output i_run, i_num_tiles, i_mode, i_axi_done, i_ntt_done, i_madd_done, i_wruram_done,
        input  o_ntt_start, o_madd_start, o_wruram_start, o_sel_axi, o_sel_ntt, o_sel_out,
               o_idx_split, o_busy, o_job_done, o_err, o_dbg_state
    );

endinterface

// File: rtl/dp_done_latch.sv
// Sticky per-core done flags for one pipeline stage; clear wins over set.
module dp_done_latch #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic [N-1:0] set,
    output logic         all_set
);

    logic [N-1:0] flags;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags <= '0;
        end else if (clr) begin
            flags <= '0;
        end else begin
            flags <= flags | set;
        end
    end

    assign all_set = &flags;

endmodule

// File: rtl/dp_pipe_sched.sv
// Three-stage rotating tile pipeline scheduler: AXI fill, NTT, and an OUT stage
// (MADD or URAM write), with buffer-role rotation at every round end.
module dp_pipe_sched
    import dp_pipe_sched_pkg::*;
#(
    parameter int NUM_CORE      = 2,
    parameter int NUM_BUF       = 3,
    parameter int NUM_SPLIT     = 4,
    parameter int LOG_NUM_SPLIT = 2,
    parameter int TILE_W        = 16
) (
    input logic            clk,
    input logic            rst_n,
    dp_pipe_sched_if.slave bus
);

    logic [1:0]               state;
    logic [1:0]               mode_q;
    logic [TILE_W-1:0]        num_q;
    logic [TILE_W:0]          round_q;
    logic [1:0]               sel_axi_q;
    logic [1:0]               sel_ntt_q;
    logic [1:0]               sel_out_q;
    logic [LOG_NUM_SPLIT-1:0] idx_q;
    logic                     ntt_start_q;
    logic                     madd_start_q;
    logic                     wruram_start_q;
    logic                     err_q;

    logic [TILE_W:0]     num_ext;
    logic [TILE_W:0]     last_round;
    logic                in_run;
    logic                run_ok;
    logic                run_bad;
    logic                axi_valid;
    logic                ntt_valid;
    logic                out_valid;
    logic                axi_all;
    logic                ntt_all;
    logic                out_all;
    logic                round_end;
    logic                last;
    logic                flag_clr;
    logic                any_done;
    logic                done_err;
    logic                axi_set;
    logic [NUM_CORE-1:0] ntt_set;
    logic [NUM_CORE-1:0] out_set;
    logic [NUM_CORE-1:0] out_done;

    assign num_ext    = {1'b0, num_q};
    assign last_round = num_ext + {{TILE_W{1'b0}}, 1'b1};
    assign in_run     = (state == S_RUN);

    assign run_ok  = (state == S_IDLE) && bus.i_run && (bus.i_num_tiles != '0) && mode_legal(bus.i_mode);
    assign run_bad = (state == S_IDLE) && bus.i_run && !((bus.i_num_tiles != '0) && mode_legal(bus.i_mode));

    // Round r: AXI holds tile r, NTT tile r-1, OUT tile r-2.
    assign axi_valid = in_run && (round_q < num_ext);
    assign ntt_valid = in_run && (round_q != '0) && (round_q <= num_ext);
    assign out_valid = in_run && (round_q >= (TILE_W+1)'(2)) && (round_q <= last_round);

    assign round_end = in_run && (!axi_valid || axi_all) && (!ntt_valid || ntt_all)
                              && (!out_valid || out_all);
    assign last      = (round_q == last_round);
    assign flag_clr  = round_end || run_ok;

    assign out_done = (mode_q == M_PTXT) ? bus.i_madd_done : {NUM_CORE{bus.i_wruram_done}};

    // Done pulses in the rotation cycle belong to no tile and are dropped.
    assign axi_set = bus.i_axi_done && axi_valid && !round_end;
    assign ntt_set = (ntt_valid && !round_end) ? bus.i_ntt_done : '0;
    assign out_set = (out_valid && !round_end) ? out_done : '0;

    assign any_done = bus.i_axi_done || (|bus.i_ntt_done) || (|bus.i_madd_done) || bus.i_wruram_done;
    assign done_err = (round_end && any_done)
                   || (bus.i_axi_done && !axi_valid)
                   || ((|bus.i_ntt_done) && !ntt_valid)
                   || ((|bus.i_madd_done) && !(out_valid && (mode_q == M_PTXT)))
                   || (bus.i_wruram_done && !(out_valid && (mode_q == M_CTXT)));

    dp_done_latch #(.N(1)) u_axi_latch (
        .clk(clk), .rst_n(rst_n), .clr(flag_clr), .set(axi_set), .all_set(axi_all)
    );

    dp_done_latch #(.N(NUM_CORE)) u_ntt_latch (
        .clk(clk), .rst_n(rst_n), .clr(flag_clr), .set(ntt_set), .all_set(ntt_all)
    );

    dp_done_latch #(.N(NUM_CORE)) u_out_latch (
        .clk(clk), .rst_n(rst_n), .clr(flag_clr), .set(out_set), .all_set(out_all)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            mode_q         <= '0;
            num_q          <= '0;
            round_q        <= '0;
            sel_axi_q      <= 2'd0;
            sel_ntt_q      <= 2'd1;
            sel_out_q      <= 2'd2;
            idx_q          <= '0;
            ntt_start_q    <= 1'b0;
            madd_start_q   <= 1'b0;
            wruram_start_q <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            ntt_start_q    <= 1'b0;
            madd_start_q   <= 1'b0;
            wruram_start_q <= 1'b0;

            if (run_ok) begin
                err_q <= 1'b0;
            end else if (run_bad || done_err) begin
                err_q <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (run_ok) begin
                        state   <= S_RUN;
                        mode_q  <= bus.i_mode;
                        num_q   <= bus.i_num_tiles;
                        round_q <= '0;
                        idx_q   <= '0;
                    end
                end
                S_RUN: begin
                    if (round_end) begin
                        if (last) begin
                            state <= S_DONE;
                        end else begin
                            round_q   <= round_q + 1'b1;
                            sel_axi_q <= ptr_next(sel_axi_q, NUM_BUF);
                            sel_ntt_q <= ptr_next(sel_ntt_q, NUM_BUF);
                            sel_out_q <= ptr_next(sel_out_q, NUM_BUF);
                            if (ntt_valid) begin
                                idx_q <= (idx_q == LOG_NUM_SPLIT'(NUM_SPLIT - 1)) ? '0 : idx_q + 1'b1;
                            end
                            // Start the stages that hold a tile in the next round.
                            ntt_start_q    <= (round_q < num_ext);
                            madd_start_q   <= (round_q != '0) && (round_q <= num_ext) && (mode_q == M_PTXT);
                            wruram_start_q <= (round_q != '0) && (round_q <= num_ext) && (mode_q == M_CTXT);
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_ntt_start    = ntt_start_q;
    assign bus.o_madd_start   = madd_start_q;
    assign bus.o_wruram_start = wruram_start_q;
    assign bus.o_sel_axi      = sel_axi_q;
    assign bus.o_sel_ntt      = sel_ntt_q;
    assign bus.o_sel_out      = sel_out_q;
    assign bus.o_idx_split    = idx_q;
    assign bus.o_busy         = (state != S_IDLE);
    assign bus.o_job_done     = (state == S_DONE);
    assign bus.o_err          = err_q;
    assign bus.o_dbg_state    = state;

endmodule

// File: tb/tb_dp_pipe_sched.sv
// Directed bench for dp_pipe_sched: run-request table, whole-job table with a
// pointer/split scoreboard, and hand sequences for skew, drop, and mid-job reset.
module tb_dp_pipe_sched;
    import dp_pipe_sched_pkg::*;

    localparam int NC = 2;
    localparam int TW = 16;
    localparam int LS = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dp_pipe_sched_if #(.NUM_CORE(NC), .TILE_W(TW), .LOG_NUM_SPLIT(LS)) bus ();

    dp_pipe_sched #(
        .NUM_CORE(NC), .NUM_BUF(3), .NUM_SPLIT(4), .LOG_NUM_SPLIT(LS), .TILE_W(TW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    typedef struct {
        int         num;
        logic [1:0] mode;
        int         exp_err;
        int         exp_busy;
    } req_t;

    typedef struct {
        int         num;
        logic [1:0] mode;
        int         skew;
        int         exp_ntt;
        int         exp_madd;
        int         exp_wr;
        int         exp_rounds;
    } job_t;

    req_t reqs[4];
    job_t jobs[4];

    logic [5:0]    exp_q[$];
    logic [LS-1:0] exp_idx_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int n_ntt = 0;
    int n_madd = 0;
    int n_wr = 0;
    int n_jd = 0;

    // Start/done pulse monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (bus.o_ntt_start)    n_ntt++;
        if (bus.o_madd_start)   n_madd++;
        if (bus.o_wruram_start) n_wr++;
        if (bus.o_job_done)     n_jd++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [5:0] sel_now();
        return {bus.o_sel_axi, bus.o_sel_ntt, bus.o_sel_out};
    endfunction

    task automatic clear_dones();
        bus.i_axi_done    = 1'b0;
        bus.i_ntt_done    = '0;
        bus.i_madd_done   = '0;
        bus.i_wruram_done = 1'b0;
    endtask

    task automatic clear_inputs();
        bus.i_run       = 1'b0;
        bus.i_num_tiles = '0;
        bus.i_mode      = 2'b00;
        clear_dones();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_sel"}, int'(sel_now()), int'(6'b00_01_10));
        check({tag, "_busy"}, int'(bus.o_busy), 0);
        check({tag, "_err"}, int'(bus.o_err), 0);
        check({tag, "_job_done"}, int'(bus.o_job_done), 0);
        check({tag, "_starts"}, int'({bus.o_ntt_start, bus.o_madd_start, bus.o_wruram_start}), 0);
        check({tag, "_idx"}, int'(bus.o_idx_split), 0);
        check({tag, "_state"}, int'(bus.o_dbg_state), int'(S_IDLE));
    endtask

    // Called at a negedge; returns at the negedge after the sampling edge.
    task automatic pulse_run(input int num, input logic [1:0] mode);
        bus.i_run       = 1'b1;
        bus.i_num_tiles = TW'(num);
        bus.i_mode      = mode;
        @(negedge clk);
        bus.i_run = 1'b0;
    endtask

    task automatic wait_round_end(input logic [1:0] old_axi, output int lat, output bit fin);
        lat = 0;
        fin = 1'b0;
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            if (i == 1) clear_dones();
            if (bus.o_job_done) begin
                fin = 1'b1;
                lat = i;
                break;
            end
            if (bus.o_sel_axi != old_axi) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic do_round(input int r, input int num, input logic [1:0] mode, input int skew);
        int d_axi;
        int d_ntt[NC];
        int d_out[NC];
        int last;
        bit a_act;
        bit n_act;
        bit o_act;
        a_act = (r < num);
        n_act = (r >= 1) && (r <= num);
        o_act = (r >= 2) && (r <= num + 1);
        d_axi = int'($urandom_range(skew, 0));
        for (int k = 0; k < NC; k++) begin
            d_ntt[k] = int'($urandom_range(skew, 0));
            d_out[k] = (mode == M_CTXT && k > 0) ? d_out[0] : int'($urandom_range(skew, 0));
        end
        last = 0;
        if (a_act && d_axi > last) last = d_axi;
        for (int k = 0; k < NC; k++) begin
            if (n_act && d_ntt[k] > last) last = d_ntt[k];
            if (o_act && d_out[k] > last) last = d_out[k];
        end
        for (int c = 0; c <= last; c++) begin
            if (c > 0) @(negedge clk);
            bus.i_axi_done = a_act && (d_axi == c);
            for (int k = 0; k < NC; k++) begin
                bus.i_ntt_done[k]  = n_act && (d_ntt[k] == c);
                bus.i_madd_done[k] = o_act && (mode == M_PTXT) && (d_out[k] == c);
            end
            bus.i_wruram_done = o_act && (mode == M_CTXT) && (d_out[0] == c);
        end
    endtask

    task automatic run_rounds(input int r0, input int r_end, input int num,
                              input logic [1:0] mode, input int skew, output int rounds);
        logic [1:0] old;
        int lat;
        bit fin;
        rounds = 0;
        for (int r = r0; r <= r_end; r++) begin
            if (exp_q.size() > 0) check("sel_seq", int'(sel_now()), int'(exp_q.pop_front()));
            if (r >= 1 && r <= num && exp_idx_q.size() > 0)
                check("idx_split", int'(bus.o_idx_split), int'(exp_idx_q.pop_front()));
            old = bus.o_sel_axi;
            do_round(r, num, mode, skew);
            wait_round_end(old, lat, fin);
            rounds++;
            check("round_lat", lat, 2);
            check("job_done_at_end", int'(fin), int'(r == num + 1));
            if (lat == 0 || fin) break;
        end
    endtask

    initial begin
        logic [1:0] old;
        int lat;
        bit fin;
        bit rot;
        int rounds;
        int b_ntt;
        int b_madd;
        int b_wr;
        int b_jd;

        reqs[0] = '{0, M_PTXT, 1, 0};
        reqs[1] = '{4, 2'b11, 1, 0};
        reqs[2] = '{4, 2'b00, 1, 0};
        reqs[3] = '{3, M_CTXT, 0, 1};

        jobs[0] = '{5, M_CTXT, 6, 5, 0, 5, 7};
        jobs[1] = '{1, M_PTXT, 0, 1, 1, 0, 3};
        jobs[2] = '{2, M_PTXT, 3, 2, 2, 0, 4};
        jobs[3] = '{3, M_CTXT, 0, 3, 0, 3, 5};

        // Pointer triples {axi,ntt,out} for each round of the 5-tile job.
        exp_q.push_back(6'b00_01_10);
        exp_q.push_back(6'b01_10_00);
        exp_q.push_back(6'b10_00_01);
        exp_q.push_back(6'b00_01_10);
        exp_q.push_back(6'b01_10_00);
        exp_q.push_back(6'b10_00_01);
        exp_q.push_back(6'b00_01_10);
        exp_idx_q.push_back(2'd0);
        exp_idx_q.push_back(2'd1);
        exp_idx_q.push_back(2'd2);
        exp_idx_q.push_back(2'd3);
        exp_idx_q.push_back(2'd0);

        clear_inputs();
        do_reset();
        check_reset_vals("reset");

        // A done pulse while idle is a protocol error.
        bus.i_madd_done = 2'b01;
        @(negedge clk);
        clear_dones();
        check("idle_done_err", int'(bus.o_err), 1);
        check("idle_done_busy", int'(bus.o_busy), 0);

        do_reset();
        for (int i = 0; i < 4; i++) begin
            pulse_run(reqs[i].num, reqs[i].mode);
            check($sformatf("req%0d_err", i), int'(bus.o_err), reqs[i].exp_err);
            check($sformatf("req%0d_busy", i), int'(bus.o_busy), reqs[i].exp_busy);
        end
        pulse_run(7, 2'b11);
        check("run_while_busy_err", int'(bus.o_err), 0);
        check("run_while_busy_state", int'(bus.o_dbg_state), int'(S_RUN));

        for (int i = 0; i < 4; i++) begin
            do_reset();
            b_ntt  = n_ntt;
            b_madd = n_madd;
            b_wr   = n_wr;
            b_jd   = n_jd;
            pulse_run(jobs[i].num, jobs[i].mode);
            check($sformatf("job%0d_busy", i), int'(bus.o_busy), 1);
            run_rounds(0, jobs[i].num + 1, jobs[i].num, jobs[i].mode, jobs[i].skew, rounds);
            check($sformatf("job%0d_rounds", i), rounds, jobs[i].exp_rounds);
            @(negedge clk);
            check($sformatf("job%0d_idle", i), int'(bus.o_busy), 0);
            check($sformatf("job%0d_err", i), int'(bus.o_err), 0);
            check($sformatf("job%0d_ntt_starts", i), n_ntt - b_ntt, jobs[i].exp_ntt);
            check($sformatf("job%0d_madd_starts", i), n_madd - b_madd, jobs[i].exp_madd);
            check($sformatf("job%0d_wr_starts", i), n_wr - b_wr, jobs[i].exp_wr);
            check($sformatf("job%0d_job_done", i), n_jd - b_jd, 1);
        end
        check("sel_q_drained", exp_q.size(), 0);
        check("idx_q_drained", exp_idx_q.size(), 0);

        // Second NTT core reports 20 cycles after the first.
        do_reset();
        pulse_run(2, M_PTXT);
        old = bus.o_sel_axi;
        bus.i_axi_done = 1'b1;
        wait_round_end(old, lat, fin);
        check("skew_r0_lat", lat, 2);
        check("skew_ntt_start", int'(bus.o_ntt_start), 1);
        old = bus.o_sel_axi;
        bus.i_axi_done = 1'b1;
        bus.i_ntt_done = 2'b01;
        rot = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            clear_dones();
            if (bus.o_sel_axi != old || bus.o_madd_start) rot = 1'b1;
        end
        check("skew_no_rotation", int'(rot), 0);
        bus.i_ntt_done = 2'b10;
        wait_round_end(old, lat, fin);
        check("skew_second_lat", lat, 2);
        check("skew_madd_start", int'(bus.o_madd_start), 1);
        run_rounds(2, 3, 2, M_PTXT, 0, rounds);
        check("skew_tail_rounds", rounds, 2);

        // Done pulse landing in the rotation cycle.
        do_reset();
        pulse_run(1, M_PTXT);
        old = bus.o_sel_axi;
        bus.i_axi_done = 1'b1;
        @(negedge clk);
        bus.i_axi_done = 1'b0;
        bus.i_ntt_done = 2'b11;
        check("drop_not_rotated_yet", int'(bus.o_sel_axi == old), 1);
        @(negedge clk);
        clear_dones();
        check("drop_err", int'(bus.o_err), 1);
        check("drop_rotated", int'(bus.o_sel_axi != old), 1);
        check("drop_ntt_start", int'(bus.o_ntt_start), 1);
        old = bus.o_sel_axi;
        rot = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.o_sel_axi != old) rot = 1'b1;
        end
        check("drop_flag_not_set", int'(rot), 0);
        run_rounds(1, 2, 1, M_PTXT, 0, rounds);
        check("drop_tail_rounds", rounds, 2);
        @(negedge clk);
        check("drop_err_sticky", int'(bus.o_err), 1);

        // Reset in the middle of round 2.
        do_reset();
        b_jd = n_jd;
        pulse_run(3, M_CTXT);
        run_rounds(0, 1, 3, M_CTXT, 0, rounds);
        check("midrst_wr_start", int'(bus.o_wruram_start), 1);
        check("midrst_sel_r2", int'(sel_now()), int'(6'b10_00_01));
        bus.i_axi_done = 1'b1;
        bus.i_ntt_done = 2'b01;
        @(negedge clk);
        clear_dones();
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_vals("midrst");
        rst_n = 1'b1;
        b_ntt = n_ntt + n_madd + n_wr;
        repeat (10) @(negedge clk);
        check("midrst_no_starts", n_ntt + n_madd + n_wr - b_ntt, 0);
        check("midrst_no_job_done", n_jd - b_jd, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
